// File: rtl/switch_event_log.sv
// Switch front-end: 2-flop sync, tick-sampled debounce, rising-edge event log shown on 7-seg, event counter on green LEDs.
// Event pulse/history/count update one cycle after the debounced level rises; no backpressure, events are never stalled.
module switch_event_log #(
  parameter int NUM_SW          = 16,
  parameter int DEPTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                   Clock_50,
  input  logic                   Resetn,
  input  logic [NUM_SW-1:0]      SWITCH_I,
  input  logic                   CLEAR_I,
  output logic [DEPTH-1:0][6:0]  SEVEN_SEGMENT_N_O,
  output logic [NUM_SW-1:0]      LED_RED_O,
  output logic [8:0]             LED_GREEN_O,
  output logic                   EVENT_VALID_O,
  output logic [3:0]             EVENT_INDEX_O
);

  localparam int TW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_SW-1:0]     r_sync1, r_sync2, r_samp, r_deb, r_deb_q;
  logic [TW-1:0]         r_tick_cnt;
  logic                  r_evt_vld;
  logic [3:0]            r_evt_idx;
  logic [DEPTH-1:0][3:0] r_hist;
  logic [DEPTH-1:0]      r_hist_vld;
  logic [7:0]            r_count;
  logic                  r_flag;

  logic                  w_tick;
  logic [NUM_SW-1:0]     w_eq, w_rise;
  logic [3:0]            w_idx;
  logic                  w_multi;

  assign w_tick  = (r_tick_cnt == TICK_LAST);
  assign w_eq    = ~(r_sync2 ^ r_samp);
  assign w_rise  = r_deb & ~r_deb_q;
  assign w_multi = |(w_rise & (w_rise - NUM_SW'(1)));

  always_comb begin
    w_idx = '0;
    for (int i = NUM_SW - 1; i >= 0; i--) begin
      if (w_rise[i]) w_idx = 4'(i);
    end
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_samp     <= '0;
      r_deb      <= '0;
      r_deb_q    <= '0;
      r_tick_cnt <= '0;
    end else begin
      r_sync1    <= SWITCH_I;
      r_sync2    <= r_sync1;
      r_deb_q    <= r_deb;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      // a bit is accepted only when this tick's level matches the previous tick's sample
      if (w_tick) begin
        r_samp <= r_sync2;
        r_deb  <= (r_deb & ~w_eq) | (r_sync2 & w_eq);
      end
    end
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_evt_vld  <= 1'b0;
      r_evt_idx  <= '0;
      r_hist     <= '0;
      r_hist_vld <= '0;
      r_count    <= '0;
      r_flag     <= 1'b0;
    end else begin
      r_evt_vld <= 1'b0;
      if (CLEAR_I) begin
        r_hist_vld <= '0;
        r_count    <= '0;
        r_flag     <= 1'b0;
      end else if (|w_rise) begin
        r_evt_vld <= 1'b1;
        r_evt_idx <= w_idx;
        for (int i = DEPTH - 1; i > 0; i--) begin
          r_hist[i]     <= r_hist[i-1];
          r_hist_vld[i] <= r_hist_vld[i-1];
        end
        r_hist[0]     <= w_idx;
        r_hist_vld[0] <= 1'b1;
        r_count       <= r_count + 8'd1;
        if (w_multi) r_flag <= 1'b1;
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    SEVEN_SEGMENT_N_O = '1;
    for (int i = 0; i < DEPTH; i++) begin
      SEVEN_SEGMENT_N_O[i] = r_hist_vld[i] ? seg7(r_hist[i]) : 7'h7F;
    end
  end

  assign LED_RED_O     = r_deb;
  assign LED_GREEN_O   = {r_flag, r_count};
  assign EVENT_VALID_O = r_evt_vld;
  assign EVENT_INDEX_O = r_evt_idx;

endmodule
